// File: rtl/vg64_pkg.sv
// Shared definitions for the C64-side VRAM access paths: register offsets, FSM encoding and
// status bit positions.
package vg64_pkg;

  localparam logic [2:0] OFS_TOKEN  = 3'd0;
  localparam logic [2:0] OFS_LSB    = 3'd1;
  localparam logic [2:0] OFS_MSB    = 3'd2;
  localparam logic [2:0] OFS_RDATA  = 3'd4;
  localparam logic [2:0] OFS_STATUS = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_REQ  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;

  localparam int unsigned STAT_VALID = 7;
  localparam int unsigned STAT_ERR   = 6;
  localparam int unsigned STAT_BUSY  = 1;
  localparam int unsigned STAT_BANK  = 0;

  function automatic logic reg_hit(input logic [15:0] addr, input logic [15:0] base,
                                   input logic [2:0] ofs);
    return addr == (base + {13'd0, ofs});
  endfunction

endpackage

// File: rtl/c64_bus_sync.sv
// Brings PHI2 and R/W into the clk100 domain and turns PHI2 edges into single-cycle pulses.
module c64_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk100,
  input  logic rst,
  input  logic phi2_async,
  input  logic rw_async,
  output logic rw_sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] phi2_q;
  logic [SYNC_STAGES-1:0] rw_q;
  logic                   phi2_prev_q;

  always_ff @(posedge clk100) begin
    if (rst) begin
      phi2_q      <= '0;
      rw_q        <= '0;
      phi2_prev_q <= 1'b0;
    end else begin
      phi2_q      <= {phi2_q[SYNC_STAGES-2:0], phi2_async};
      rw_q        <= {rw_q[SYNC_STAGES-2:0], rw_async};
      phi2_prev_q <= phi2_q[SYNC_STAGES-1];
    end
  end

  assign rw_sync = rw_q[SYNC_STAGES-1];
  assign rise    = phi2_q[SYNC_STAGES-1] & ~phi2_prev_q;
  assign fall    = ~phi2_q[SYNC_STAGES-1] & phi2_prev_q;

endmodule

// File: rtl/vram_readback.sv
// C64 read path into video SRAM: snoops the address registers, prefetches the addressed byte
// through the pixel engine's req/gnt slot and serves it on a readable data register.
module vram_readback
  import vg64_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hDE00,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned GNT_TIMEOUT = 255
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        i_64clk,
  input  logic        i_64rw,
  input  logic [15:0] i_64addr,
  input  logic [7:0]  i_64data,
  output logic [7:0]  o_64data,
  output logic        o_64oe,
  output logic        o_req,
  input  logic        i_gnt,
  output logic [16:0] o_raddr,
  input  logic        i_rvalid,
  input  logic [7:0]  i_rdata
);

  localparam int unsigned TW = $clog2(GNT_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(GNT_TIMEOUT - 1);

  logic rw_s, rise, fall;

  c64_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk100    (clk100),
    .rst       (rst),
    .phi2_async(i_64clk),
    .rw_async  (i_64rw),
    .rw_sync   (rw_s),
    .rise      (rise),
    .fall      (fall)
  );

  state_t        state_q;
  logic          bank_q, valid_q, err_q, stale_q;
  logic [15:0]   addr_q;
  logic [7:0]    buf_q;
  logic [TW-1:0] tmo_q;

  logic        wr_token, wr_lsb, wr_msb, rd_data, start;
  logic        rd_hit_data, rd_hit_stat;
  logic        bank_d;
  logic [15:0] addr_d;
  logic [7:0]  status;

  always_comb begin
    wr_token    = fall & ~rw_s & reg_hit(i_64addr, BASE_ADDR, OFS_TOKEN);
    wr_lsb      = fall & ~rw_s & reg_hit(i_64addr, BASE_ADDR, OFS_LSB);
    wr_msb      = fall & ~rw_s & reg_hit(i_64addr, BASE_ADDR, OFS_MSB);
    rd_data     = fall & rw_s & reg_hit(i_64addr, BASE_ADDR, OFS_RDATA);
    start       = wr_msb | rd_data;
    rd_hit_data = rw_s & reg_hit(i_64addr, BASE_ADDR, OFS_RDATA);
    rd_hit_stat = rw_s & reg_hit(i_64addr, BASE_ADDR, OFS_STATUS);

    bank_d = wr_token ? i_64data[0] : bank_q;
    addr_d = addr_q;
    if (wr_lsb) begin
      addr_d = {addr_q[15:8], i_64data};
    end else if (wr_msb) begin
      addr_d = {i_64data, addr_q[7:0]};
    end else if (rd_data) begin
      addr_d = addr_q + 16'd1;
    end

    status             = 8'h00;
    status[STAT_VALID] = valid_q;
    status[STAT_ERR]   = err_q;
    status[STAT_BUSY]  = (state_q != ST_IDLE);
    status[STAT_BANK]  = bank_q;
  end

  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bank_q   <= 1'b0;
      addr_q   <= 16'h0000;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      stale_q  <= 1'b0;
      buf_q    <= 8'h00;
      tmo_q    <= '0;
      o_req    <= 1'b0;
      o_raddr  <= 17'h0;
      o_64oe   <= 1'b0;
      o_64data <= 8'h00;
    end else begin
      bank_q <= bank_d;
      addr_q <= addr_d;
      if (start) valid_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_REQ;
            o_req   <= 1'b1;
            o_raddr <= {bank_d, addr_d};
            tmo_q   <= '0;
          end
        end
        ST_REQ: begin
          // A grant means the old address is already sampled; a racing restart must be redone.
          if (i_gnt) begin
            state_q <= ST_WAIT;
            o_req   <= 1'b0;
            if (start) stale_q <= 1'b1;
          end else begin
            if (start) o_raddr <= {bank_d, addr_d};
            if (tmo_q == TMO_LAST) err_q <= 1'b1;
            else tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (i_rvalid) begin
            if (stale_q || start) begin
              stale_q <= 1'b0;
              state_q <= ST_REQ;
              o_req   <= 1'b1;
              o_raddr <= {bank_d, addr_d};
              tmo_q   <= '0;
            end else begin
              buf_q   <= i_rdata;
              valid_q <= 1'b1;
              state_q <= ST_IDLE;
            end
          end else if (start) begin
            stale_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      if (rise) begin
        o_64oe <= rd_hit_data | rd_hit_stat;
        if (rd_hit_data) o_64data <= buf_q;
        else if (rd_hit_stat) o_64data <= status;
      end else if (fall) begin
        o_64oe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_readback.sv
// Directed and randomized bench for vram_readback; expectations come from a register-level model.
module tb_vram_readback;

  localparam logic [15:0] BASE = 16'hDE00;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        i_64clk, i_64rw;
  logic [15:0] i_64addr;
  logic [7:0]  i_64data;
  logic [7:0]  o_64data;
  logic        o_64oe, o_req, i_gnt, i_rvalid;
  logic [16:0] o_raddr;
  logic [7:0]  i_rdata;

  vram_readback #(
    .BASE_ADDR  (BASE),
    .SYNC_STAGES(2),
    .GNT_TIMEOUT(255)
  ) dut (
    .clk100  (clk100),
    .rst     (rst),
    .i_64clk (i_64clk),
    .i_64rw  (i_64rw),
    .i_64addr(i_64addr),
    .i_64data(i_64data),
    .o_64data(o_64data),
    .o_64oe  (o_64oe),
    .o_req   (o_req),
    .i_gnt   (i_gnt),
    .o_raddr (o_raddr),
    .i_rvalid(i_rvalid),
    .i_rdata (i_rdata)
  );

  always #5 clk100 = ~clk100;

  int n_cmp = 0;
  int n_err = 0;

  // Programmer-visible model of the register block.
  logic        m_bank, m_valid, m_err, m_busy;
  logic [15:0] m_addr;
  logic [7:0]  m_buf;

  function automatic logic [7:0] exp_status();
    return {m_valid, m_err, 4'b0000, m_busy, m_bank};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk100);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_bank = 0; m_addr = 0; m_buf = 0; m_valid = 0; m_err = 0; m_busy = 0;
  endtask

  task automatic bus_write(input logic [2:0] ofs, input logic [7:0] d);
    i_64rw = 1'b0; i_64addr = BASE + {13'd0, ofs}; i_64data = d;
    i_64clk = 1'b1; tick(8);
    i_64clk = 1'b0; tick(8);
    i_64rw = 1'b1; i_64addr = 16'h0000;
    case (ofs)
      3'd0: m_bank = d[0];
      3'd1: m_addr[7:0] = d;
      3'd2: begin m_addr[15:8] = d; m_valid = 0; m_busy = 1; end
      default: ;
    endcase
  endtask

  task automatic bus_read(input logic [2:0] ofs, output logic [7:0] d);
    i_64rw = 1'b1; i_64addr = BASE + {13'd0, ofs};
    i_64clk = 1'b1; tick(8);
    chk("oe_in_read", {31'd0, o_64oe}, 32'd1);
    d = o_64data;
    i_64clk = 1'b0; tick(8);
    chk("oe_after_read", {31'd0, o_64oe}, 32'd0);
    i_64addr = 16'h0000;
  endtask

  task automatic read_status(input string tag);
    logic [7:0] d;
    bus_read(3'd5, d);
    chk(tag, {24'd0, d}, {24'd0, exp_status()});
  endtask

  task automatic read_data(input string tag);
    logic [7:0] d;
    bus_read(3'd4, d);
    chk(tag, {24'd0, d}, {24'd0, m_buf});
    m_addr = m_addr + 16'd1;
    m_valid = 0;
    m_busy = 1;
  endtask

  task automatic wait_req();
    int k = 0;
    while (!o_req && k < 40) begin tick(1); k++; end
    chk("req_seen", {31'd0, o_req}, 32'd1);
  endtask

  task automatic pulse_gnt();
    i_gnt = 1'b1; tick(1); i_gnt = 1'b0;
  endtask

  task automatic pulse_rvalid(input logic [7:0] d);
    i_rvalid = 1'b1; i_rdata = d; tick(1); i_rvalid = 1'b0;
  endtask

  // Serve one prefetch; gdly < 0 picks a random grant delay.
  task automatic serve(input logic [7:0] d, input int gdly);
    wait_req();
    chk("raddr", {15'd0, o_raddr}, {15'd0, m_bank, m_addr});
    tick(gdly < 0 ? $urandom_range(0, 6) : gdly);
    pulse_gnt();
    chk("req_drop", {31'd0, o_req}, 32'd0);
    tick($urandom_range(0, 5));
    pulse_rvalid(d);
    m_buf = d; m_valid = 1; m_busy = 0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] r;
    rst = 1'b1; i_64clk = 1'b0; i_64rw = 1'b1; i_64addr = 0; i_64data = 0;
    i_gnt = 0; i_rvalid = 0; i_rdata = 0;
    model_reset();
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_req", {31'd0, o_req}, 32'd0);
    chk("rst_oe", {31'd0, o_64oe}, 32'd0);

    // Reset in the middle of a WAIT; a late rvalid must be ignored.
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'h55);
    bus_write(3'd2, 8'h66);
    wait_req();
    pulse_gnt();
    rst = 1'b1; tick(3); rst = 1'b0; tick(1);
    model_reset();
    chk("rst2_req", {31'd0, o_req}, 32'd0);
    chk("rst2_raddr", {15'd0, o_raddr}, 32'd0);
    chk("rst2_oe", {31'd0, o_64oe}, 32'd0);
    chk("rst2_data", {24'd0, o_64data}, 32'd0);
    pulse_rvalid(8'h99);
    tick(2);
    chk("late_rvalid_req", {31'd0, o_req}, 32'd0);
    read_status("rst_status");

    // First prefetch from bank 1, 0x1234.
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'h34);
    bus_write(3'd2, 8'h12);
    chk("first_raddr", {15'd0, o_raddr}, 32'h11234);
    serve(8'hA5, 5);
    read_status("status_valid");

    // Streaming reads with auto-increment.
    read_data("rd0");
    serve(8'h01, -1);
    read_data("rd1");
    serve(8'h02, -1);
    read_data("rd2");
    serve(8'h03, -1);

    // Grant and rvalid in IDLE are ignored.
    pulse_gnt();
    pulse_rvalid(8'h5A);
    tick(2);
    chk("idle_gnt_req", {31'd0, o_req}, 32'd0);
    read_status("idle_status");

    // Randomized address loads and reads.
    for (int i = 0; i < 6; i++) begin
      if ($urandom_range(0, 1) == 1) bus_write(3'd0, 8'($urandom));
      bus_write(3'd1, 8'($urandom));
      bus_write(3'd2, 8'($urandom));
      serve(8'($urandom), -1);
      read_status("rnd_status");
      read_data("rnd_rd");
      serve(8'($urandom), -1);
    end

    // Address wrap FFFF -> 0000, bank kept.
    bus_write(3'd0, 8'h01);
    bus_write(3'd1, 8'hFF);
    bus_write(3'd2, 8'hFF);
    serve(8'($urandom), -1);
    read_data("wrap_rd");
    chk("wrap_raddr", {15'd0, o_raddr}, 32'h10000);
    serve(8'($urandom), -1);

    // Restart while in WAIT: first return discarded, new request issued.
    bus_write(3'd2, 8'h40);
    wait_req();
    pulse_gnt();
    read_status("wait_status");
    bus_write(3'd2, 8'h41);
    pulse_rvalid(8'hEE);
    tick(1);
    chk("stale_rereq", {31'd0, o_req}, 32'd1);
    chk("stale_raddr", {15'd0, o_raddr}, {15'd0, m_bank, m_addr});
    read_status("stale_status");
    serve(8'h77, -1);
    read_data("after_stale_rd");
    serve(8'($urandom), -1);

    // Grant timeout sets sticky err, request stays up.
    bus_write(3'd2, 8'h10);
    tick(190);
    read_status("pre_timeout_status");
    tick(70);
    m_err = 1;
    read_status("timeout_status");
    chk("timeout_req", {31'd0, o_req}, 32'd1);
    serve(8'h3C, 0);
    read_status("post_timeout_status");
    read_data("post_timeout_rd");
    serve(8'($urandom), -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
